// File: rtl/pio_event_master.sv
// pio_event_master
//   Avalon-MM initiator servicing a DATA_WIDTH-bit edge-capturing input PIO.
//   After reset it writes the PIO interrupt mask. On every PIO interrupt it
//   reads the edge-capture register, clears it, reads the current input
//   levels and offers one event on a valid/ready stream. Events arriving
//   while the previous one is still unconsumed are merged into it.
//
// Ports
//   clk, reset_n          system clock, asynchronous active-low reset
//   address, chipselect,  registered Avalon-MM master outputs towards the PIO
//   write_n, writedata
//   readdata              PIO read data (read latency 1)
//   irq                   PIO level interrupt
//   cfg_mask_valid/_ready runtime interrupt-mask rewrite request, cfg_mask data
//   evt_valid/_ready      event stream handshake
//   evt_capture           accumulated edge-capture bits
//   evt_level             input levels read after the clear
//   evt_overrun           event merged with an unconsumed predecessor
module pio_event_master #(
    parameter int                    DATA_WIDTH = 5,
    parameter logic [DATA_WIDTH-1:0] MASK_INIT  = 5'h1F
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic [1:0]            address,
    output logic                  chipselect,
    output logic                  write_n,
    output logic [31:0]           writedata,
    input  logic [31:0]           readdata,
    input  logic                  irq,
    input  logic                  cfg_mask_valid,
    input  logic [DATA_WIDTH-1:0] cfg_mask,
    output logic                  cfg_mask_ready,
    output logic                  evt_valid,
    input  logic                  evt_ready,
    output logic [DATA_WIDTH-1:0] evt_capture,
    output logic [DATA_WIDTH-1:0] evt_level,
    output logic                  evt_overrun
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_RDCAP,
        S_CLR,
        S_RDDAT,
        S_LATDAT
    } state_t;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_CAP  = 2'd3;

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] mask_lat;
    logic [DATA_WIDTH-1:0] cap_hold;

    logic [1:0]            address_d;
    logic                  chipselect_d;
    logic                  write_n_d;
    logic [31:0]           writedata_d;

    // Only the low DATA_WIDTH bits of the PIO registers carry information.
    logic [31-DATA_WIDTH:0] unused_readdata;
    assign unused_readdata = readdata[31:DATA_WIDTH];

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:   state_nxt = S_IDLE;
            S_IDLE: begin
                if (cfg_mask_valid) begin
                    state_nxt = S_INIT;
                end else if (irq) begin
                    state_nxt = S_RDCAP;
                end
            end
            S_RDCAP:  state_nxt = S_CLR;
            S_CLR:    state_nxt = S_RDDAT;
            S_RDDAT:  state_nxt = S_LATDAT;
            S_LATDAT: state_nxt = S_IDLE;
            default:  state_nxt = S_INIT;
        endcase
    end

    // Output logic. Bus registers are loaded from the state the bus cycle
    // belongs to, so RDCAP/CLR/RDDAT appear on the bus while the FSM is in
    // that state. The mask write is the exception: it is launched from INIT
    // and is on the bus during the first IDLE cycle, which places the first
    // write in the first clock after reset release and gives the mask
    // latch a full cycle to settle on a runtime rewrite.
    always_comb begin
        cfg_mask_ready = (state == S_IDLE);
        address_d      = ADDR_DATA;
        chipselect_d   = 1'b0;
        write_n_d      = 1'b1;
        writedata_d    = 32'h0;
        if (state == S_INIT) begin
            address_d    = ADDR_MASK;
            chipselect_d = 1'b1;
            write_n_d    = 1'b0;
            writedata_d  = {{(32-DATA_WIDTH){1'b0}}, mask_lat};
        end else begin
            case (state_nxt)
                S_RDCAP: begin
                    address_d    = ADDR_CAP;
                    chipselect_d = 1'b1;
                end
                S_CLR: begin
                    address_d    = ADDR_CAP;
                    chipselect_d = 1'b1;
                    write_n_d    = 1'b0;
                end
                S_RDDAT: begin
                    address_d    = ADDR_DATA;
                    chipselect_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Bus registers, holding registers and event output register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            address     <= ADDR_DATA;
            chipselect  <= 1'b0;
            write_n     <= 1'b1;
            writedata   <= 32'h0;
            mask_lat    <= MASK_INIT;
            cap_hold    <= '0;
            evt_valid   <= 1'b0;
            evt_capture <= '0;
            evt_level   <= '0;
            evt_overrun <= 1'b0;
        end else begin
            address    <= address_d;
            chipselect <= chipselect_d;
            write_n    <= write_n_d;
            writedata  <= writedata_d;

            if (state == S_IDLE && cfg_mask_valid) begin
                mask_lat <= cfg_mask;
            end

            // Read of the capture register issued in RDCAP returns during CLR.
            if (state == S_CLR) begin
                cap_hold <= readdata[DATA_WIDTH-1:0];
            end

            // The level read issued in RDDAT returns during LATDAT and goes
            // straight into the output register; a spurious service with no
            // captured edge produces no event.
            if (state == S_LATDAT && cap_hold != '0) begin
                if (!evt_valid || evt_ready) begin
                    evt_capture <= cap_hold;
                    evt_level   <= readdata[DATA_WIDTH-1:0];
                    evt_overrun <= 1'b0;
                    evt_valid   <= 1'b1;
                end else begin
                    evt_capture <= evt_capture | cap_hold;
                    evt_level   <= readdata[DATA_WIDTH-1:0];
                    evt_overrun <= 1'b1;
                end
            end else if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pio_event_master.sv
// Testbench for pio_event_master: a behavioural edge-capturing PIO slave,
// queues of expected bus operations and events filled by the stimulus, and
// negedge monitors that pop and compare whenever the DUT presents a bus
// cycle or completes an event handshake.
module tb_pio_event_master;

    localparam int DW = 5;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata = 32'h0;
    logic          irq;
    logic          cfg_mask_valid = 1'b0;
    logic [DW-1:0] cfg_mask = '0;
    logic          cfg_mask_ready;
    logic          evt_valid;
    logic          evt_ready = 1'b1;
    logic [DW-1:0] evt_capture;
    logic [DW-1:0] evt_level;
    logic          evt_overrun;

    int checks = 0;
    int errors = 0;

    logic [34:0]   bus_q[$];
    logic [10:0]   evt_q[$];

    always #5 clk = ~clk;

    pio_event_master dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .address        (address),
        .chipselect     (chipselect),
        .write_n        (write_n),
        .writedata      (writedata),
        .readdata       (readdata),
        .irq            (irq),
        .cfg_mask_valid (cfg_mask_valid),
        .cfg_mask       (cfg_mask),
        .cfg_mask_ready (cfg_mask_ready),
        .evt_valid      (evt_valid),
        .evt_ready      (evt_ready),
        .evt_capture    (evt_capture),
        .evt_level      (evt_level),
        .evt_overrun    (evt_overrun)
    );

    // Edge-capturing PIO slave model (any-edge capture, clear-all on write).
    logic [DW-1:0] in_port = '0;
    logic [DW-1:0] prev_in = '0;
    logic [DW-1:0] pio_cap = '0;
    logic [DW-1:0] pio_mask = '0;

    assign irq = |(pio_cap & pio_mask);

    always @(posedge clk) begin
        prev_in <= in_port;
        if (chipselect && !write_n && address == 2'd3) pio_cap <= '0;
        else pio_cap <= pio_cap | (in_port ^ prev_in);
        if (chipselect && !write_n && address == 2'd2) pio_mask <= writedata[DW-1:0];
        if (chipselect && write_n) begin
            case (address)
                2'd0:    readdata <= {27'h0, in_port};
                2'd2:    readdata <= {27'h0, pio_mask};
                2'd3:    readdata <= {27'h0, pio_cap};
                default: readdata <= 32'h0;
            endcase
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bus monitor: write data only matters for writes.
    always @(negedge clk) begin
        logic [34:0] act;
        if (reset_n && chipselect) begin
            act = {write_n, address, (write_n ? 32'h0 : writedata)};
            if (bus_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL bus_unexpected actual=%0h required=none at %0t", act, $time);
            end else begin
                chk("bus_op", 64'(act), 64'(bus_q.pop_front()));
            end
        end
    end

    // Event monitor: compares {overrun, capture, level} on each handshake.
    always @(negedge clk) begin
        logic [10:0] act;
        if (evt_valid && evt_ready) begin
            act = {evt_overrun, evt_capture, evt_level};
            if (evt_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL evt_unexpected actual=%0h required=none at %0t", act, $time);
            end else begin
                chk("evt", 64'(act), 64'(evt_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push_service();
        bus_q.push_back({1'b1, 2'd3, 32'h0});
        bus_q.push_back({1'b0, 2'd3, 32'h0});
        bus_q.push_back({1'b1, 2'd0, 32'h0});
    endtask

    task automatic push_evt(input logic [DW-1:0] c, input logic [DW-1:0] l, input logic o);
        evt_q.push_back({o, c, l});
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!evt_valid && n < 40);
        if (!evt_valid) begin
            checks++;
            errors++;
            $display("FAIL wait_valid actual=timeout required=evt_valid");
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_address"},    64'(address),        64'd0);
        chk({tag, "_chipselect"}, 64'(chipselect),     64'd0);
        chk({tag, "_write_n"},    64'(write_n),        64'd1);
        chk({tag, "_writedata"},  64'(writedata),      64'd0);
        chk({tag, "_evt_valid"},  64'(evt_valid),      64'd0);
        chk({tag, "_evt_cap"},    64'(evt_capture),    64'd0);
        chk({tag, "_evt_lvl"},    64'(evt_level),      64'd0);
        chk({tag, "_evt_ovr"},    64'(evt_overrun),    64'd0);
        chk({tag, "_cfg_ready"},  64'(cfg_mask_ready), 64'd0);
    endtask

    initial begin
        int n;
        bit found;

        // Reset and initial mask write
        step(3);
        chk_reset_vals("rst");
        bus_q.push_back({1'b0, 2'd2, 32'h1F});
        reset_n = 1'b1;
        @(negedge clk);
        chk("cycle0_idle", 64'(chipselect), 64'd0);
        @(posedge clk);
        #1;
        chk("cycle1_cs", 64'(chipselect), 64'd1);
        chk("cycle1_addr", 64'(address), 64'd2);
        step(6);
        chk("init_no_evt", 64'(evt_valid), 64'd0);
        chk("init_idle_ready", 64'(cfg_mask_ready), 64'd1);

        // Single edge, consumer ready
        push_service();
        push_evt(5'h04, 5'h04, 1'b0);
        in_port = 5'h04;
        wait_valid(n);
        chk("svc_latency", 64'(n), 64'd7);
        @(negedge clk);
        chk("evt_one_cycle", 64'(evt_valid), 64'd0);
        step(3);
        chk("cap_cleared", 64'(pio_cap), 64'd0);

        // Stalled consumer: second event merges
        evt_ready = 1'b0;
        push_service();
        in_port = 5'h05;
        wait_valid(n);
        step(3);
        push_service();
        push_evt(5'h09, 5'h0D, 1'b1);
        in_port = 5'h0D;
        step(10);
        chk("merge_valid", 64'(evt_valid), 64'd1);
        chk("merge_ovr", 64'(evt_overrun), 64'd1);
        chk("merge_cap", 64'(evt_capture), 64'h09);
        evt_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("accept_clears", 64'(evt_valid), 64'd0);
        chk("cap_holds", 64'(evt_capture), 64'h09);

        // Mask rewrite simultaneous with irq: write goes first
        step(1);
        in_port = 5'h0F;
        step(1);
        cfg_mask = 5'h02;
        cfg_mask_valid = 1'b1;
        bus_q.push_back({1'b0, 2'd2, 32'h02});
        push_service();
        push_evt(5'h02, 5'h0F, 1'b0);
        @(negedge clk);
        chk("cfg_irq_both", 64'({cfg_mask_ready, irq}), 64'b11);
        step(1);
        cfg_mask_valid = 1'b0;
        wait_valid(n);
        step(2);

        // Masked bit 4 toggles silently, then bit 1 reports both
        in_port = 5'h1F;
        step(10);
        chk("masked_no_irq", 64'(irq), 64'd0);
        chk("masked_no_evt", 64'(evt_valid), 64'd0);
        chk("masked_captured", 64'(pio_cap), 64'h10);
        push_service();
        push_evt(5'h12, 5'h1D, 1'b0);
        in_port = 5'h1D;
        wait_valid(n);
        step(3);
        chk("cap_cleared2", 64'(pio_cap), 64'd0);

        // Reset pulse during CLR
        bus_q.push_back({1'b1, 2'd3, 32'h0});
        bus_q.push_back({1'b0, 2'd3, 32'h0});
        in_port = 5'h1F;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk);
            if (chipselect && !write_n && address == 2'd3) found = 1'b1;
        end
        chk("clr_seen", 64'(found), 64'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("arst");
        step(2);
        bus_q.push_back({1'b0, 2'd2, 32'h1F});
        push_service();
        push_evt(5'h02, 5'h1F, 1'b0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reinit_cs", 64'(chipselect), 64'd1);
        chk("reinit_wd", 64'(writedata), 64'h1F);
        wait_valid(n);
        step(5);

        chk("bus_q_empty", 64'(bus_q.size()), 64'd0);
        chk("evt_q_empty", 64'(evt_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
